// File: rtl/regfile_wb_sink.sv
// 32x32 RV32I register file fed by the writeback stage; two registered read ports.
// Read latency is 1 cycle; writes are never stalled. REGFILE_BYPASS_EN selects write-first reads.
module regfile_wb_sink #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rw_in,
    input  logic [XLEN-1:0] writedata_in,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rd_en,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic [31:0]     wr_count
);

    // x0 has no storage; address 0 is decoded to zero on the read side.
    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic            r_rd_valid;
    logic [31:0]     r_wr_count;

    logic            w_wr_en;
    logic            w_byp1;
    logic            w_byp2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_wr_en = (rw_in != '0);

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = w_wr_en && (rw_in == rs1_addr);
    assign w_byp2 = w_wr_en && (rw_in == rs2_addr);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    always_comb begin
        w_rs1_val = '0;
        if (rs1_addr != '0) begin
            w_rs1_val = w_byp1 ? writedata_in : r_regs[rs1_addr];
        end
    end

    always_comb begin
        w_rs2_val = '0;
        if (rs2_addr != '0) begin
            w_rs2_val = w_byp2 ? writedata_in : r_regs[rs2_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_en) begin
            r_regs[rw_in] <= writedata_in;
            r_wr_count    <= r_wr_count + 32'd1;
        end
    end

    // Read data holds while rd_en is low; only the valid flag drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rs1_data <= w_rs1_val;
                r_rs2_data <= w_rs2_val;
            end
        end
    end

    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign rd_valid = r_rd_valid;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed vector bench for regfile_wb_sink, valid for both bypass builds.
module tb_regfile_wb_sink;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rw_in = '0;
    logic [31:0] writedata_in = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;
    logic [31:0] wr_count;

    int total = 0;
    int bad   = 0;

    regfile_wb_sink dut (
        .clk          (clk),
        .reset        (reset),
        .rw_in        (rw_in),
        .writedata_in (writedata_in),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_en        (rd_en),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_valid     (rd_valid),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] wdata;
        logic        rden;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ev;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic ev, input logic [31:0] ecnt);
        chk({tag, ".rs1"}, rs1_data, e1);
        chk({tag, ".rs2"}, rs2_data, e2);
        chk({tag, ".vld"}, {31'd0, rd_valid}, {31'd0, ev});
        chk({tag, ".cnt"}, wr_count, ecnt);
    endtask

    task automatic drive(input logic [4:0] rw, input logic [31:0] d, input logic rden,
                         input logic [4:0] a1, input logic [4:0] a2);
        rw_in = rw; writedata_in = d; rd_en = rden; rs1_addr = a1; rs2_addr = a2;
    endtask

    initial begin
        //          rw     wdata          rden a1  a2   e1                              e2             ev    ecnt
        vecs[0]  = '{5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0,                         32'h0,         1'b0, 32'd1};
        vecs[1]  = '{5'd0,  32'h0,        1'b1, 5'd5, 5'd0, 32'hDEADBEEF,                  32'h0,         1'b1, 32'd1};
        vecs[2]  = '{5'd0,  32'h12345678, 1'b1, 5'd0, 5'd5, 32'h0,                         32'hDEADBEEF,  1'b1, 32'd1};
        vecs[3]  = '{5'd7,  32'h1,        1'b0, 5'd0, 5'd0, 32'h0,                         32'hDEADBEEF,  1'b0, 32'd2};
        vecs[4]  = '{5'd7,  32'hA5A5A5A5, 1'b1, 5'd7, 5'd5, BYP ? 32'hA5A5A5A5 : 32'h1,    32'hDEADBEEF,  1'b1, 32'd3};
        vecs[5]  = '{5'd0,  32'h0,        1'b1, 5'd7, 5'd7, 32'hA5A5A5A5,                  32'hA5A5A5A5,  1'b1, 32'd3};
        vecs[6]  = '{5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 32'hA5A5A5A5,                  32'hA5A5A5A5,  1'b0, 32'd4};
        vecs[7]  = '{5'd1,  32'h1,        1'b0, 5'd0, 5'd0, 32'hA5A5A5A5,                  32'hA5A5A5A5,  1'b0, 32'd5};
        vecs[8]  = '{5'd0,  32'h0,        1'b1, 5'd31, 5'd1, 32'hFFFFFFFF,                 32'h1,         1'b1, 32'd5};
        vecs[9]  = '{5'd2,  32'hCAFE0002, 1'b1, 5'd1, 5'd2, 32'h1,                         BYP ? 32'hCAFE0002 : 32'h0, 1'b1, 32'd6};
        vecs[10] = '{5'd0,  32'h0,        1'b1, 5'd0, 5'd0, 32'h0,                         32'h0,         1'b1, 32'd6};

        // Reset state
        repeat (2) @(negedge clk);
        chk_all("reset", 32'h0, 32'h0, 1'b0, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].wdata, vecs[i].rden, vecs[i].a1, vecs[i].a2);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ev, vecs[i].ecnt);
        end

        // Mid-stream asynchronous reset discards the pending write and read
        @(negedge clk);
        drive(5'd9, 32'h00000077, 1'b1, 5'd5, 5'd9);
        #2 reset = 1'b1;
        #1;
        chk_all("arst", 32'h0, 32'h0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk_all("arst_hold", 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        drive(5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(5'd0, 32'h0, 1'b1, 5'(i), 5'(32 - i));
            @(posedge clk);
            #1;
            chk($sformatf("clr_rs1_x%0d", i), rs1_data, 32'h0);
            chk($sformatf("clr_rs2_x%0d", 32 - i), rs2_data, 32'h0);
        end
        chk("clr_vld", {31'd0, rd_valid}, 32'd1);
        chk("clr_cnt", wr_count, 32'd0);

        // Counter wrap via backdoor preload
        @(negedge clk);
        drive(5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        force dut.r_wr_count = 32'hFFFFFFFF;
        #1 release dut.r_wr_count;
        chk("preload", wr_count, 32'hFFFFFFFF);
        drive(5'd3, 32'h00000033, 1'b1, 5'd1, 5'd2);
        @(posedge clk);
        #1;
        chk_all("wrap", 32'h0, 32'h0, 1'b1, 32'd0);

        @(negedge clk);
        drive(5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
        @(posedge clk);
        #1;
        chk_all("idle_hold", 32'h0, 32'h0, 1'b0, 32'd0);

        @(negedge clk);
        drive(5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
        @(posedge clk);
        #1;
        chk_all("rd_x3", 32'h00000033, 32'h0, 1'b1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
